// File: rtl/tt_lut_filt.sv
// tt_lut_filt: runtime-loadable N-input truth-table gate with a persistence-filtered registered output.
// Optional build macro TT_LUT_GLITCH_CNT_EN adds a saturating count of aborted output transitions.
module tt_lut_filt #(
   parameter int N_IN  = 3,
   parameter int TT_W  = 2**N_IN,
   parameter int DELAY = 4,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_valid,
   input  logic [TT_W-1:0] cfg_tt,
   output logic            cfg_ready,
   input  logic [N_IN-1:0] in,
   output logic            out,
   output logic            out_valid,
   output logic            cfg_loaded
`ifdef TT_LUT_GLITCH_CNT_EN
   ,
   output logic [15:0]     glitch_cnt
`endif
);
   typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;
   localparam logic [CNT_W-1:0] DLY = CNT_W'(DELAY);
   state_t          state;
   logic [TT_W-1:0] tt;
   logic [CNT_W-1:0] cnt;
   logic [N_IN-1:0] idx;
   logic            f;
   logic            hs;
   // table MSB holds pattern 0, so the bit index is the bitwise complement of the pattern
   assign idx       = ~in;
   assign f         = tt[idx];
   assign cfg_ready = state != LOAD;
   assign hs        = cfg_valid & cfg_ready;
   assign out_valid = (state == RUN) & (f == out) & (cnt == '0);
   // configuration FSM and persistence filter; a load always costs one LOAD cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= UNCFG;
         tt         <= '0;
         out        <= 1'b0;
         cnt        <= '0;
         cfg_loaded <= 1'b0;
      end else begin
         case (state)
            UNCFG: if (hs) begin
               tt         <= cfg_tt;
               cfg_loaded <= 1'b1;
               state      <= LOAD;
            end
            LOAD: begin
               cnt   <= '0;
               state <= RUN;
            end
            RUN: if (hs) begin
               tt         <= cfg_tt;
               cfg_loaded <= 1'b1;
               cnt        <= '0;
               state      <= LOAD;
            end else if (f == out) begin
               cnt <= '0;
            end else if (cnt == DLY) begin
               out <= f;
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            default: state <= UNCFG;
         endcase
      end
   end
`ifdef TT_LUT_GLITCH_CNT_EN
   // counts transitions abandoned because f fell back to out before the flip edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         glitch_cnt <= '0;
      else if (hs)
         glitch_cnt <= '0;
      else if (state == RUN && f == out && cnt != '0 && glitch_cnt != 16'hFFFF)
         glitch_cnt <= glitch_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_tt_lut_filt.sv
// tb_tt_lut_filt: table-driven and sequence checks for tt_lut_filt (DELAY=4 instance and DELAY=0 instance).
module tb_tt_lut_filt;
   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid, cfg_valid_b;
   logic [7:0] cfg_tt, cfg_tt_b;
   logic [2:0] in, in_b;
   logic       cfg_ready, out, out_valid, cfg_loaded;
   logic       cfg_ready_b, out_b, out_valid_b, cfg_loaded_b;
`ifdef TT_LUT_GLITCH_CNT_EN
   logic [15:0] glitch_cnt, glitch_cnt_b;
`endif
   int passed = 0;
   int total = 0;
   bit exp_q[$];

   typedef struct {logic [2:0] pat; logic exp;} vec_t;
   vec_t vec[8];

   tt_lut_filt #(.N_IN(3), .DELAY(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_tt(cfg_tt), .cfg_ready(cfg_ready),
      .in(in), .out(out), .out_valid(out_valid), .cfg_loaded(cfg_loaded)
`ifdef TT_LUT_GLITCH_CNT_EN
      , .glitch_cnt(glitch_cnt)
`endif
   );

   tt_lut_filt #(.N_IN(3), .DELAY(0), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid_b), .cfg_tt(cfg_tt_b), .cfg_ready(cfg_ready_b),
      .in(in_b), .out(out_b), .out_valid(out_valid_b), .cfg_loaded(cfg_loaded_b)
`ifdef TT_LUT_GLITCH_CNT_EN
      , .glitch_cnt(glitch_cnt_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic load_a(input logic [7:0] t);
      cfg_valid = 1'b1;
      cfg_tt = t;
      step();
      chk("load_cfg_ready_low", cfg_ready, 1'b0);
      chk("load_out_valid_low", out_valid, 1'b0);
      chk("load_cfg_loaded", cfg_loaded, 1'b1);
      cfg_valid = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      bit prev, e;
      vec[0] = '{3'd0, 1'b1}; vec[1] = '{3'd1, 1'b1}; vec[2] = '{3'd2, 1'b1}; vec[3] = '{3'd3, 1'b0};
      vec[4] = '{3'd4, 1'b1}; vec[5] = '{3'd5, 1'b0}; vec[6] = '{3'd6, 1'b0}; vec[7] = '{3'd7, 1'b1};
      rst = 1'b1; cfg_valid = 1'b1; cfg_tt = 8'hE9; in = 3'd0;
      cfg_valid_b = 1'b0; cfg_tt_b = 8'h00; in_b = 3'd0;
      step(2);
      chk("rst_out", out, 1'b0);
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      chk("rst_cfg_loaded", cfg_loaded, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      rst = 1'b0; cfg_valid = 1'b0;
      step();
      chk("post_rst_no_load", cfg_loaded, 1'b0);
      load_a(8'hE9);
      step(4);
      chk("first_settle_before", out, 1'b0);
      step();
      chk("first_settle_flip", out, 1'b1);
      chk("first_settle_valid", out_valid, 1'b1);
      prev = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in = vec[k].pat;
         exp_q.push_back(vec[k].exp);
         for (int j = 1; j <= 10; j++) begin
            step();
            if (prev != vec[k].exp && j == 4) chk($sformatf("sweep%0d_hold", k), out, prev);
            if (prev != vec[k].exp && j == 5) chk($sformatf("sweep%0d_flip", k), out, vec[k].exp);
         end
         e = exp_q.pop_front();
         chk($sformatf("sweep%0d_out", k), out, e);
         chk($sformatf("sweep%0d_valid", k), out_valid, 1'b1);
         prev = e;
      end
      in = 3'd0;
      step(2);
      in = 3'd3;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("glitch_hold", out, 1'b1);
         chk("glitch_not_valid", out_valid, 1'b0);
      end
      in = 3'd0;
      step();
      chk("glitch_out", out, 1'b1);
      chk("glitch_valid", out_valid, 1'b1);
`ifdef TT_LUT_GLITCH_CNT_EN
      chk("glitch_cnt", glitch_cnt, 16'd1);
`endif
      in = 3'd3;
      step(2);
      cfg_valid = 1'b1; cfg_tt = 8'hFF;
      step();
      chk("reload_ready_low", cfg_ready, 1'b0);
      chk("reload_out", out, 1'b1);
      chk("reload_valid_low", out_valid, 1'b0);
      cfg_valid = 1'b0;
      step();
      chk("reload_cnt_cleared", out_valid, 1'b1);
      step(6);
      chk("reload_out_stable", out, 1'b1);
`ifdef TT_LUT_GLITCH_CNT_EN
      chk("reload_glitch_clr", glitch_cnt, 16'd0);
`endif
      cfg_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("cont_ready%0d", i), cfg_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
         chk($sformatf("cont_out%0d", i), out, 1'b1);
      end
      cfg_valid = 1'b0;
      step();
      in = 3'd0;
      load_a(8'hE9);
      step();
      in = 3'd3;
      step(2);
      #2 rst = 1'b1;
      #1;
      chk("arst_out", out, 1'b0);
      chk("arst_cfg_loaded", cfg_loaded, 1'b0);
      chk("arst_cfg_ready", cfg_ready, 1'b1);
      chk("arst_out_valid", out_valid, 1'b0);
      rst = 1'b0;
      step(3);
      chk("arst_unconfig_valid", out_valid, 1'b0);
      chk("arst_unconfig_out", out, 1'b0);
      in = 3'd0;
      load_a(8'hE9);
      chk("arst_reload_valid_low", out_valid, 1'b0);
      step(5);
      chk("arst_reload_out", out, 1'b1);
      chk("arst_reload_valid", out_valid, 1'b1);
      cfg_valid_b = 1'b1; cfg_tt_b = 8'h80; in_b = 3'd0;
      step();
      chk("d0_load_ready_low", cfg_ready_b, 1'b0);
      cfg_valid_b = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         in_b = (i % 2 == 0) ? 3'd0 : 3'd1;
         exp_q.push_back(in_b == 3'd0);
         step();
         e = exp_q.pop_front();
         chk($sformatf("d0_follow%0d", i), out_b, e);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tt_lut_filt.md
Name: tt_lut_filt

Overview:
- Parametrised successor to the fixed 3-input truth-table gate blocks.
- Evaluates a runtime-loadable N-input Boolean function. The truth table uses the same hex naming as the gate library: MSB corresponds to input pattern 0.
- Registered output with a persistence filter: the output changes only after the new value has held for DELAY+1 consecutive cycles. This models gate response time and suppresses input glitches.
- Sits between input-pattern stimulus and downstream gate/reporter models in circuit-level simulation.

Parameters:
- N_IN, 3, number of function inputs (1..6).
- TT_W, 2**N_IN, truth-table width (derived; do not override).
- DELAY, 4, extra consecutive cycles the new value must persist before out changes (0..255).
- CNT_W, 8, persistence-counter width; must hold DELAY.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- cfg_valid  input  1  truth-table load request
- cfg_tt  input  TT_W  table; cfg_tt[TT_W-1-k] = output for input pattern k
- cfg_ready  output  1  load accepted when cfg_valid & cfg_ready
- in  input  N_IN  pattern; in[N_IN-1] is MSB (in1 of the gate naming)
- out  output  1  filtered, registered function output
- out_valid  output  1  configured and settled (out == f, counter 0)
- cfg_loaded  output  1  a table has been accepted since reset

Behaviour:
- Reset (async, immediate):
  - tt=0, out=0, cnt=0, cfg_loaded=0, out_valid=0, cfg_ready=1, state=UNCFG.
  - Reset mid-load or mid-count discards everything.
- Combinational f = tt[TT_W-1-in]. Example: cfg_tt=8'hE9 gives 000→1, 011→0, 111→1.
- FSM states: UNCFG, LOAD, RUN.
  - UNCFG: out held 0, out_valid=0, cfg_ready=1. On handshake: tt<=cfg_tt, cfg_loaded<=1, go to LOAD.
  - LOAD (exactly 1 cycle): cfg_ready=0, cnt<=0, out holds, out_valid=0. Then go to RUN.
  - RUN: cfg_ready=1. On handshake: tt<=cfg_tt, cnt<=0, go to LOAD. The filter is not evaluated on the handshake edge.
- Filter in RUN, evaluated per edge without a handshake:
  - if f==out: cnt<=0.
  - else if cnt==DELAY: out<=f, cnt<=0.
  - else: cnt<=cnt+1.
- Latency:
  - The first edge with f!=out is e0; out flips at edge e0+DELAY.
  - DELAY=0 gives plain 1-cycle registered output.
- Glitch: f returning to out before the flip edge clears cnt and leaves out unchanged.
- out_valid = (state==RUN) & (f==out) & (cnt==0). It is combinational from registered state and in.
- Reloading with an identical table still passes through LOAD; out is not disturbed.
- cfg_valid held high continuously: a reload is accepted every second cycle (LOAD, RUN, LOAD, …). This is legal and out never changes.
- No arithmetic overflow: cnt never exceeds DELAY.

Optional Feature:
- Macro: TT_LUT_GLITCH_CNT_EN.
- When defined:
  - Adds output glitch_cnt [15:0].
  - It increments, saturating at 16'hFFFF, on every RUN edge where f==out and cnt!=0 (an aborted transition).
  - Cleared by rst and on each accepted config.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset state: assert rst with cfg_valid=1 → out=0, cfg_ready=1, cfg_loaded=0, out_valid=0; no load occurs during reset.
- Full function: load 8'hE9 with DELAY=4, then sweep in=0..7 holding each pattern 10 cycles → out = 1,1,1,0,1,0,0,1. Each change lands exactly 5 edges after the pattern edge.
- Glitch reject: load 8'hE9 with in=3'b000 and let it settle (out=1). Drive in=3'b011 for 3 cycles, then back to 000 → out stays 1, out_valid returns 1; glitch_cnt=1 if the macro is enabled.
- Reconfig mid-count: load 8'hE9 with in=000 and out settled to 1. Apply in=011 for 2 cycles, then load 8'hFF → cnt cleared, out stays 1, LOAD cycle shows cfg_ready=0.
- DELAY=0 build: load 8'h80 (only pattern 0 true). Toggle in 000↔001 every cycle → out follows f with exactly 1-cycle latency.
- Async reset mid-RUN: assert rst between edges while cnt=2 → out=0 and cfg_loaded=0 immediately; next table load is required before out_valid rises.
